// File: rtl/ex_mem_if.sv
// ID/EX-to-EX/MEM bundle: the id_ex fields the execute stage consumes and the
// registered EX/MEM results it hands to the MEM stage.
interface ex_mem_if #(parameter int WIDTH = 32);
  logic             ctrl_regWrite_id_ex;
  logic             ctrl_memToReg_id_ex;
  logic             ctrl_branch_id_ex;
  logic             ctrl_memRead_id_ex;
  logic             ctrl_memWrite_id_ex;
  logic             ctrl_regDest_id_ex;
  logic             ctrl_aluSrc_id_ex;
  logic [1:0]       ctrl_aluOp_id_ex;
  logic [WIDTH-1:0] supposed_next_address_id_ex;
  logic [WIDTH-1:0] read_data_1_id_ex;
  logic [WIDTH-1:0] read_data_2_id_ex;
  logic [WIDTH-1:0] extended_branch_offset_id_ex;
  logic [4:0]       next_instruction_20_16_id_ex;
  logic [4:0]       next_instruction_15_11_id_ex;

  logic             ctrl_regWrite_ex_mem;
  logic             ctrl_memToReg_ex_mem;
  logic             ctrl_branch_ex_mem;
  logic             ctrl_memRead_ex_mem;
  logic             ctrl_memWrite_ex_mem;
  logic [WIDTH-1:0] branch_target_ex_mem;
  logic             zero_ex_mem;
  logic [WIDTH-1:0] alu_result_ex_mem;
  logic [WIDTH-1:0] write_data_ex_mem;
  logic [4:0]       write_reg_ex_mem;

  modport master (
    output ctrl_regWrite_id_ex, ctrl_memToReg_id_ex, ctrl_branch_id_ex,
           ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_regDest_id_ex,
           ctrl_aluSrc_id_ex, ctrl_aluOp_id_ex, supposed_next_address_id_ex,
           read_data_1_id_ex, read_data_2_id_ex, extended_branch_offset_id_ex,
           next_instruction_20_16_id_ex, next_instruction_15_11_id_ex,
    input  ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem, ctrl_branch_ex_mem,
           ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, branch_target_ex_mem,
           zero_ex_mem, alu_result_ex_mem, write_data_ex_mem, write_reg_ex_mem
  );

  modport slave (
    input  ctrl_regWrite_id_ex, ctrl_memToReg_id_ex, ctrl_branch_id_ex,
           ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_regDest_id_ex,
           ctrl_aluSrc_id_ex, ctrl_aluOp_id_ex, supposed_next_address_id_ex,
           read_data_1_id_ex, read_data_2_id_ex, extended_branch_offset_id_ex,
           next_instruction_20_16_id_ex, next_instruction_15_11_id_ex,
    output ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem, ctrl_branch_ex_mem,
           ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, branch_target_ex_mem,
           zero_ex_mem, alu_result_ex_mem, write_data_ex_mem, write_reg_ex_mem
  );
endinterface

// File: rtl/ex_mem.sv
// MIPS execute stage (ALU control, ALU, branch target, dest select) and the
// EX/MEM register; one-cycle latency, stall holds, flush zeroes the controls.
module ex_mem #(parameter int WIDTH = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  ex_mem_if.slave      bus
);
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_zero;
  logic [WIDTH-1:0] w_branch_target;
  logic [4:0]       w_write_reg;
  logic [5:0]       w_funct;

  logic             r_regWrite, r_memToReg, r_branch, r_memRead, r_memWrite;
  logic [WIDTH-1:0] r_branch_target, r_alu_result, r_write_data;
  logic             r_zero;
  logic [4:0]       r_write_reg;

  assign w_funct = bus.extended_branch_offset_id_ex[5:0];
  assign w_alu_b = bus.ctrl_aluSrc_id_ex ? bus.extended_branch_offset_id_ex
                                         : bus.read_data_2_id_ex;

  always_comb begin
    w_alu_res = '0;
    case (bus.ctrl_aluOp_id_ex)
      2'b01: w_alu_res = bus.read_data_1_id_ex - w_alu_b;
      2'b10: begin
        // R-type: an unrecognised funct yields zero rather than a default op
        case (w_funct)
          6'h20: w_alu_res = bus.read_data_1_id_ex + w_alu_b;
          6'h22: w_alu_res = bus.read_data_1_id_ex - w_alu_b;
          6'h24: w_alu_res = bus.read_data_1_id_ex & w_alu_b;
          6'h25: w_alu_res = bus.read_data_1_id_ex | w_alu_b;
          6'h27: w_alu_res = ~(bus.read_data_1_id_ex | w_alu_b);
          6'h2A: w_alu_res = ($signed(bus.read_data_1_id_ex) < $signed(w_alu_b))
                             ? WIDTH'(1) : '0;
          default: w_alu_res = '0;
        endcase
      end
      default: w_alu_res = bus.read_data_1_id_ex + w_alu_b;
    endcase
  end

  assign w_zero          = (w_alu_res == '0);
  assign w_branch_target = bus.supposed_next_address_id_ex +
                           {bus.extended_branch_offset_id_ex[WIDTH-3:0], 2'b00};
  assign w_write_reg     = bus.ctrl_regDest_id_ex ? bus.next_instruction_15_11_id_ex
                                                  : bus.next_instruction_20_16_id_ex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regWrite      <= 1'b0;
      r_memToReg      <= 1'b0;
      r_branch        <= 1'b0;
      r_memRead       <= 1'b0;
      r_memWrite      <= 1'b0;
      r_branch_target <= '0;
      r_zero          <= 1'b0;
      r_alu_result    <= '0;
      r_write_data    <= '0;
      r_write_reg     <= '0;
    end else if (flush || !stall) begin
      // a bubble still loads the datapath; only the controls are forced low
      r_regWrite      <= bus.ctrl_regWrite_id_ex & ~flush;
      r_memToReg      <= bus.ctrl_memToReg_id_ex & ~flush;
      r_branch        <= bus.ctrl_branch_id_ex   & ~flush;
      r_memRead       <= bus.ctrl_memRead_id_ex  & ~flush;
      r_memWrite      <= bus.ctrl_memWrite_id_ex & ~flush;
      r_branch_target <= w_branch_target;
      r_zero          <= w_zero;
      r_alu_result    <= w_alu_res;
      r_write_data    <= bus.read_data_2_id_ex;
      r_write_reg     <= w_write_reg;
    end
  end

  assign bus.ctrl_regWrite_ex_mem = r_regWrite;
  assign bus.ctrl_memToReg_ex_mem = r_memToReg;
  assign bus.ctrl_branch_ex_mem   = r_branch;
  assign bus.ctrl_memRead_ex_mem  = r_memRead;
  assign bus.ctrl_memWrite_ex_mem = r_memWrite;
  assign bus.branch_target_ex_mem = r_branch_target;
  assign bus.zero_ex_mem          = r_zero;
  assign bus.alu_result_ex_mem    = r_alu_result;
  assign bus.write_data_ex_mem    = r_write_data;
  assign bus.write_reg_ex_mem     = r_write_reg;
endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: hand-computed vectors through a single checker.
module tb_ex_mem;
  logic clk;
  logic reset;
  logic stall;
  logic flush;
  int   n_chk;
  int   n_err;

  ex_mem_if #(.WIDTH(32)) bus ();

  ex_mem #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.ctrl_regWrite_id_ex          = 1'b0;
    bus.ctrl_memToReg_id_ex          = 1'b0;
    bus.ctrl_branch_id_ex            = 1'b0;
    bus.ctrl_memRead_id_ex           = 1'b0;
    bus.ctrl_memWrite_id_ex          = 1'b0;
    bus.ctrl_regDest_id_ex           = 1'b0;
    bus.ctrl_aluSrc_id_ex            = 1'b0;
    bus.ctrl_aluOp_id_ex             = 2'b00;
    bus.supposed_next_address_id_ex  = 32'h0;
    bus.read_data_1_id_ex            = 32'h0;
    bus.read_data_2_id_ex            = 32'h0;
    bus.extended_branch_offset_id_ex = 32'h0;
    bus.next_instruction_20_16_id_ex = 5'd0;
    bus.next_instruction_15_11_id_ex = 5'd0;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    clr_in();
    bus.ctrl_aluOp_id_ex             = 2'b10;
    bus.extended_branch_offset_id_ex = {26'h0, funct};
    bus.read_data_1_id_ex            = a;
    bus.read_data_2_id_ex            = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".regWrite"}, {31'h0, bus.ctrl_regWrite_ex_mem}, 32'h0);
    chk({tag, ".memToReg"}, {31'h0, bus.ctrl_memToReg_ex_mem}, 32'h0);
    chk({tag, ".branch"},   {31'h0, bus.ctrl_branch_ex_mem},   32'h0);
    chk({tag, ".memRead"},  {31'h0, bus.ctrl_memRead_ex_mem},  32'h0);
    chk({tag, ".memWrite"}, {31'h0, bus.ctrl_memWrite_ex_mem}, 32'h0);
    chk({tag, ".target"},   bus.branch_target_ex_mem,          32'h0);
    chk({tag, ".zero"},     {31'h0, bus.zero_ex_mem},          32'h0);
    chk({tag, ".alu"},      bus.alu_result_ex_mem,             32'h0);
    chk({tag, ".wdata"},    bus.write_data_ex_mem,             32'h0);
    chk({tag, ".wreg"},     {27'h0, bus.write_reg_ex_mem},     32'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    clr_in();
    // random inputs during reset must not leak through
    for (int i = 0; i < 4; i++) begin
      bus.ctrl_regWrite_id_ex          = 1'b1;
      bus.ctrl_memRead_id_ex           = 1'b1;
      bus.ctrl_aluOp_id_ex             = 2'($urandom_range(0, 3));
      bus.read_data_1_id_ex            = $urandom;
      bus.read_data_2_id_ex            = $urandom;
      bus.extended_branch_offset_id_ex = $urandom;
      bus.supposed_next_address_id_ex  = $urandom;
      bus.next_instruction_20_16_id_ex = 5'($urandom);
      step();
    end
    chk_all_zero("reset");

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_release_alu", bus.alu_result_ex_mem, 32'h0);

    rtype(6'h20, 32'd5, 32'd7);
    bus.ctrl_regDest_id_ex           = 1'b1;
    bus.next_instruction_20_16_id_ex = 5'd7;
    bus.next_instruction_15_11_id_ex = 5'd9;
    step();
    chk("add.alu",  bus.alu_result_ex_mem, 32'd12);
    chk("add.wreg", {27'h0, bus.write_reg_ex_mem}, 32'd9);
    chk("add.zero", {31'h0, bus.zero_ex_mem}, 32'd0);

    rtype(6'h24, 32'hF0F0F0F0, 32'h0F0F0F0F); step();
    chk("and.alu",  bus.alu_result_ex_mem, 32'h0);
    chk("and.zero", {31'h0, bus.zero_ex_mem}, 32'd1);
    rtype(6'h25, 32'hF0F0F0F0, 32'h0F0F0F0F); step();
    chk("or.alu",   bus.alu_result_ex_mem, 32'hFFFFFFFF);
    chk("or.zero",  {31'h0, bus.zero_ex_mem}, 32'd0);
    rtype(6'h27, 32'hF0F0F0F0, 32'h0F0F0F0F); step();
    chk("nor.alu",  bus.alu_result_ex_mem, 32'h0);
    rtype(6'h2A, 32'hFFFFFFFF, 32'd1); step();
    chk("slt.neg",  bus.alu_result_ex_mem, 32'd1);
    rtype(6'h2A, 32'd1, 32'hFFFFFFFF); step();
    chk("slt.pos",  bus.alu_result_ex_mem, 32'd0);
    rtype(6'h22, 32'd10, 32'd3); step();
    chk("subf.alu", bus.alu_result_ex_mem, 32'd7);
    rtype(6'h21, 32'd10, 32'd3); step();
    chk("badfn.alu", bus.alu_result_ex_mem, 32'h0);

    clr_in();
    bus.ctrl_aluOp_id_ex  = 2'b01;
    bus.read_data_1_id_ex = 32'h0;
    bus.read_data_2_id_ex = 32'h1;
    step();
    chk("subwrap.alu", bus.alu_result_ex_mem, 32'hFFFFFFFF);

    clr_in();
    bus.ctrl_aluOp_id_ex             = 2'b01;
    bus.ctrl_branch_id_ex            = 1'b1;
    bus.read_data_1_id_ex            = 32'h1234;
    bus.read_data_2_id_ex            = 32'h1234;
    bus.supposed_next_address_id_ex  = 32'h100;
    bus.extended_branch_offset_id_ex = 32'hFFFFFFFE;
    step();
    chk("beq.zero",   {31'h0, bus.zero_ex_mem}, 32'd1);
    chk("beq.target", bus.branch_target_ex_mem, 32'hF8);
    chk("beq.branch", {31'h0, bus.ctrl_branch_ex_mem}, 32'd1);

    clr_in();
    bus.ctrl_aluOp_id_ex             = 2'b00;
    bus.ctrl_aluSrc_id_ex            = 1'b1;
    bus.ctrl_memRead_id_ex           = 1'b1;
    bus.ctrl_memToReg_id_ex          = 1'b1;
    bus.ctrl_regWrite_id_ex          = 1'b1;
    bus.read_data_1_id_ex            = 32'h1000;
    bus.read_data_2_id_ex            = 32'h5555;
    bus.extended_branch_offset_id_ex = 32'h10;
    bus.next_instruction_20_16_id_ex = 5'd3;
    bus.next_instruction_15_11_id_ex = 5'd17;
    step();
    chk("lw.alu",      bus.alu_result_ex_mem, 32'h1010);
    chk("lw.memRead",  {31'h0, bus.ctrl_memRead_ex_mem}, 32'd1);
    chk("lw.memToReg", {31'h0, bus.ctrl_memToReg_ex_mem}, 32'd1);
    chk("lw.regWrite", {31'h0, bus.ctrl_regWrite_ex_mem}, 32'd1);
    chk("lw.wreg",     {27'h0, bus.write_reg_ex_mem}, 32'd3);

    clr_in();
    bus.ctrl_aluSrc_id_ex            = 1'b1;
    bus.ctrl_memWrite_id_ex          = 1'b1;
    bus.read_data_1_id_ex            = 32'h2000;
    bus.read_data_2_id_ex            = 32'hDEADBEEF;
    bus.extended_branch_offset_id_ex = 32'h4;
    step();
    chk("sw.wdata",    bus.write_data_ex_mem, 32'hDEADBEEF);
    chk("sw.alu",      bus.alu_result_ex_mem, 32'h2004);
    chk("sw.memWrite", {31'h0, bus.ctrl_memWrite_ex_mem}, 32'd1);
    chk("sw.memRead",  {31'h0, bus.ctrl_memRead_ex_mem}, 32'd0);

    clr_in();
    bus.ctrl_aluOp_id_ex    = 2'b11;
    bus.ctrl_regWrite_id_ex = 1'b1;
    bus.read_data_1_id_ex   = 32'd3;
    bus.read_data_2_id_ex   = 32'd4;
    step();
    chk("op11.alu", bus.alu_result_ex_mem, 32'd7);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.read_data_1_id_ex            = 32'd100 + 32'(k);
      bus.ctrl_memWrite_id_ex          = 1'b1;
      bus.next_instruction_20_16_id_ex = 5'd20;
      step();
      chk("stall.alu",      bus.alu_result_ex_mem, 32'd7);
      chk("stall.memWrite", {31'h0, bus.ctrl_memWrite_ex_mem}, 32'd0);
      chk("stall.wreg",     {27'h0, bus.write_reg_ex_mem}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall.alu",      bus.alu_result_ex_mem, 32'd106);
    chk("unstall.memWrite", {31'h0, bus.ctrl_memWrite_ex_mem}, 32'd1);
    chk("unstall.wreg",     {27'h0, bus.write_reg_ex_mem}, 32'd20);

    clr_in();
    bus.ctrl_regWrite_id_ex = 1'b1;
    bus.ctrl_memToReg_id_ex = 1'b1;
    bus.ctrl_branch_id_ex   = 1'b1;
    bus.ctrl_memRead_id_ex  = 1'b1;
    bus.ctrl_memWrite_id_ex = 1'b1;
    bus.read_data_1_id_ex   = 32'd40;
    bus.read_data_2_id_ex   = 32'd2;
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("flush.regWrite", {31'h0, bus.ctrl_regWrite_ex_mem}, 32'd0);
    chk("flush.memToReg", {31'h0, bus.ctrl_memToReg_ex_mem}, 32'd0);
    chk("flush.branch",   {31'h0, bus.ctrl_branch_ex_mem},   32'd0);
    chk("flush.memRead",  {31'h0, bus.ctrl_memRead_ex_mem},  32'd0);
    chk("flush.memWrite", {31'h0, bus.ctrl_memWrite_ex_mem}, 32'd0);
    chk("flush.alu",      bus.alu_result_ex_mem, 32'd42);
    stall = 1'b0;
    flush = 1'b0;

    step();
    chk("pre_arst.regWrite", {31'h0, bus.ctrl_regWrite_ex_mem}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    chk("hold_reset.alu", bus.alu_result_ex_mem, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
